count_sequence_controller: RTL and testbench

- Sequencer for the 4-bit synchronous counter: runs it from 0 up to a programmable terminal count.
- Drives the counter's count_enable and clear pins and watches its Q outputs.
- Terminal count is handled one-shot or periodically. Supports pause and abort.
- Reports busy, a per-period done pulse and a completed-period count to the surrounding control logic.

---
 rtl/count_sequence_controller.sv | 119 +++++++++++
 tb/tb_count_sequence_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_controller.sv
// ==========================================================================
// count_sequence_controller: runs an external 4-bit counter from 0 to a latched limit,
// one-shot or periodic, with hold/stop. Optional prescaler: COUNT_SEQ_PRESCALE_EN.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module count_sequence_controller #(
   parameter int WIDTH = 4,
   parameter int PC_W  = 8,
   parameter int PRE_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             periodic,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             count_enable,
   output logic             cnt_clear,
   output logic             busy,
   output logic             done,
   output logic [PC_W-1:0]  period_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_lim;
   logic             r_per;
   logic             w_load;
   logic             w_term_hit;
   logic             w_at_term;
   logic             w_tick;

   assign w_at_term = (cnt_q == r_lim);

`ifdef COUNT_SEQ_PRESCALE_EN
   logic [PRE_W-1:0] r_pre;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_pre <= '0;
      end else if (r_state == ST_CLR) begin
         r_pre <= '0;
      end else if (r_state == ST_RUN && !hold) begin
         r_pre <= r_pre + 1'b1;
      end
   end

   assign w_tick = &r_pre;
`else
   // Without the prescaler the counter may advance every cycle.
   assign w_tick = (PRE_W >= 0);
`endif

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_term_hit = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = ST_CLR;
            end
         end
         ST_CLR: w_next = ST_RUN;
         ST_RUN: begin
            if (w_at_term) begin
               w_term_hit = 1'b1;
               w_next     = r_per ? ST_CLR : ST_DONE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort overrides start and the terminal event alike.
      if (stop) begin
         w_next     = ST_IDLE;
         w_load     = 1'b0;
         w_term_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state    <= ST_IDLE;
         r_lim      <= '0;
         r_per      <= 1'b0;
         done       <= 1'b0;
         period_cnt <= '0;
      end else begin
         r_state <= w_next;
         done    <= w_term_hit;
         if (w_load) begin
            r_lim      <= limit;
            r_per      <= periodic;
            period_cnt <= '0;
         end else if (w_term_hit) begin
            period_cnt <= period_cnt + 1'b1;
         end
      end
   end

   assign count_enable = (r_state == ST_RUN) & ~hold & ~w_at_term & w_tick;
   assign cnt_clear    = clear | (r_state == ST_CLR);
   assign busy         = (r_state == ST_CLR) | (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_count_sequence_controller.sv
// ==========================================================================
// tb_count_sequence_controller: directed bench with counter models and a done scoreboard.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_count_sequence_controller;

   localparam int WIDTH = 4;
   localparam int PRE_W = 2;
`ifdef COUNT_SEQ_PRESCALE_EN
   localparam int S = 1 << PRE_W;
`else
   localparam int S = 1;
`endif

   logic             clk = 1'b0;
   logic             clear, start, stop, hold, periodic;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] cnt_q, cnt_q2;
   logic             count_enable, cnt_clear, busy, done;
   logic             count_enable2, cnt_clear2, busy2, done2;
   logic [7:0]       period_cnt;
   logic [1:0]       period_cnt2;

   always #5 clk = ~clk;

   count_sequence_controller #(.WIDTH(WIDTH), .PC_W(8), .PRE_W(PRE_W)) dut (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .hold(hold),
      .periodic(periodic), .limit(limit), .cnt_q(cnt_q),
      .count_enable(count_enable), .cnt_clear(cnt_clear), .busy(busy),
      .done(done), .period_cnt(period_cnt)
   );

   count_sequence_controller #(.WIDTH(WIDTH), .PC_W(2), .PRE_W(PRE_W)) dut2 (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .hold(hold),
      .periodic(periodic), .limit(limit), .cnt_q(cnt_q2),
      .count_enable(count_enable2), .cnt_clear(cnt_clear2), .busy(busy2),
      .done(done2), .period_cnt(period_cnt2)
   );

   // External 4-bit counters with asynchronous clear
   always_ff @(posedge clk or posedge cnt_clear) begin
      if (cnt_clear) cnt_q <= '0;
      else if (count_enable) cnt_q <= cnt_q + 1'b1;
   end
   always_ff @(posedge clk or posedge cnt_clear2) begin
      if (cnt_clear2) cnt_q2 <= '0;
      else if (count_enable2) cnt_q2 <= cnt_q2 + 1'b1;
   end

   int cyc = 0;
   always_ff @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int pc;
   } exp_t;
   exp_t sbq[$];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
         chk("done_missing", cyc, sbq[0].cyc);
         void'(sbq.pop_front());
      end
      if (done) begin
         if (sbq.size() == 0) begin
            chk("done_unexpected", done, 0);
         end else begin
            e = sbq.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("period_cnt", period_cnt, e.pc);
            chk("period_cnt_w2", period_cnt2, e.pc % 4);
            chk("done_w2", done2, 1);
         end
      end
   end

   // Drive start at the current negedge; expect n done pulses, the first delayed by extra.
   task automatic do_start(input int lim, input logic per, input int n, input int extra);
      int c;
      int p;
      c = cyc;
      p = lim * S + 2;
      limit    = 4'(lim);
      periodic = per;
      start    = 1'b1;
      for (int k = 1; k <= n; k++) sbq.push_back('{c + 1 + k * p + extra, k});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cnt(input logic [WIDTH-1:0] v, input int bound);
      int i;
      i = 0;
      while (cnt_q !== v && i < bound) begin
         @(negedge clk);
         i++;
      end
      chk("wait_cnt", cnt_q, v);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int c0;
      int p;
      int en_cnt;
      clear = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; periodic = 1'b0; limit = '0;

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_cnt_clear", cnt_clear, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_period_cnt", period_cnt, 0);
      chk("rst_count_enable", count_enable, 0);
      chk("rst_cnt_q", cnt_q, 0);
      clear = 1'b0;
      @(negedge clk);
      chk("idle_cnt_clear", cnt_clear, 0);
      chk("idle_busy", busy, 0);

      // One-shot, limit 5
      p = 5 * S + 2;
      do_start(5, 1'b0, 1, 0);
      chk("os_clr_cycle", cnt_clear, 1);
      chk("os_busy", busy, 1);
      chk("os_en_in_clr", count_enable, 0);
      en_cnt = 0;
      repeat (p - 1) begin
         @(negedge clk);
         en_cnt += int'(count_enable);
      end
      chk("os_en_pulses", en_cnt, 5);
      chk("os_term_cnt_q", cnt_q, 5);
      chk("os_term_en", count_enable, 0);
      repeat (2) @(negedge clk);
      chk("os_done_busy", busy, 0);
      chk("os_done_period_cnt", period_cnt, 1);
      chk("os_done_cnt_q", cnt_q, 5);
      chk("os_done_cnt_clear", cnt_clear, 0);

      // Periodic limit 3 started from DONE; a start pulse during RUN is ignored
      c0 = cyc;
      p = 3 * S + 2;
      do_start(3, 1'b1, 4, 0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      limit = 4'd9;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 1 + 4 * p) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("per_stop_busy", busy, 0);
      chk("per_stop_cnt_clear", cnt_clear, 0);
      chk("per_period_cnt", period_cnt, 4);
      chk("per_period_cnt_wrap", period_cnt2, 0);

      // Hold for 3 cycles at cnt_q=2, limit 6
      c0 = cyc;
      p = 6 * S + 2;
      do_start(6, 1'b0, 1, 3);
      wait_cnt(4'd2, 4 * S + 4);
      hold = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("hold_cnt_q", cnt_q, 2);
         chk("hold_en", count_enable, 0);
      end
      hold = 1'b0;
      while (cyc < c0 + 1 + p + 3 + 1) @(negedge clk);
      chk("hold_busy", busy, 0);
      chk("hold_period_cnt", period_cnt, 1);
      chk("hold_cnt_q_final", cnt_q, 6);

      // Stop from DONE keeps the counter value; stop wins over start in IDLE
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_done_busy", busy, 0);
      chk("stop_done_cnt_q", cnt_q, 6);
      start = 1'b1;
      stop  = 1'b1;
      limit = 4'd4;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_cnt_clear", cnt_clear, 0);
      @(negedge clk);
      chk("start_stop_busy2", busy, 0);
      chk("start_stop_cnt_q", cnt_q, 6);

      // Stop in the terminal cycle of the second period
      c0 = cyc;
      p = 2 * S + 2;
      do_start(2, 1'b1, 1, 0);
      while (cyc < c0 + 2 * p) @(negedge clk);
      chk("term_stop_cnt_q", cnt_q, 2);
      chk("term_stop_busy_pre", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("term_stop_busy", busy, 0);
      chk("term_stop_done", done, 0);
      chk("term_stop_period_cnt", period_cnt, 1);
      chk("term_stop_cnt_q_kept", cnt_q, 2);

      // limit 0, periodic: 2-cycle periods, no enables
      c0 = cyc;
      do_start(0, 1'b1, 3, 0);
      en_cnt = 0;
      while (cyc < c0 + 1 + 3 * 2) begin
         @(negedge clk);
         en_cnt += int'(count_enable);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("lim0_en_pulses", en_cnt, 0);
      chk("lim0_period_cnt", period_cnt, 3);

      // Asynchronous clear mid-run at cnt_q=3
      do_start(5, 1'b0, 0, 0);
      wait_cnt(4'd3, 4 * S + 6);
      clear = 1'b1;
      #1;
      chk("aclr_cnt_clear", cnt_clear, 1);
      chk("aclr_cnt_q", cnt_q, 0);
      chk("aclr_busy", busy, 0);
      chk("aclr_period_cnt", period_cnt, 0);
      chk("aclr_done", done, 0);
      @(negedge clk);
      clear = 1'b0;
      repeat (2) @(negedge clk);
      chk("aclr_idle_busy", busy, 0);
      chk("aclr_idle_cnt_clear", cnt_clear, 0);
      chk("aclr_idle_en", count_enable, 0);

      chk("scoreboard_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
